// File: rtl/uart_tx_engine.sv
// uart_tx_engine: serial transmit engine of the UART.
// Accepts bytes over a valid/ready handshake and sends each one as an
// asynchronous frame: start bit, data LSB first, optional parity, and one
// or two stop bits. The baud divisor and frame format are captured when the
// byte is accepted, so CSR writes made during a frame apply from the next frame.
// Build option: define UART_TX_PARITY_EN to compile in the PARITY state and
// the parity generator. Without it, parity_en/parity_odd are ignored.
module uart_tx_engine #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic              tx_en,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              stop2,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              busy,
    output logic              free
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [IDX_W-1:0]   bit_idx_r;
    logic [IDX_W-1:0]   next_idx_s;
    logic [DIV_W-1:0]   baud_cnt_r;
    logic [DIV_W-1:0]   next_cnt_s;
    logic [DATA_W-1:0]  data_r;
    logic [DATA_W-1:0]  next_data_s;
    logic [DIV_W-1:0]   div_r;
    logic               stop2_r;
    logic               tx_r;
    logic               next_tx_s;
    logic               busy_r;
    logic               accept_s;
    logic               tick_s;

`ifdef UART_TX_PARITY_EN
    logic               par_en_r;
    logic               par_odd_r;

    // Parity bit over the data word: even parity is the XOR of all bits,
    // odd parity is its complement.
    function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction
`else
    // Parity controls have no effect in this build; keep them referenced.
    logic               unused_par_cfg_s;
    assign unused_par_cfg_s = parity_en ^ parity_odd;
`endif

    assign tx_ready = (state_r == ST_IDLE) && tx_en;
    assign free     = tx_ready;
    assign accept_s = tx_valid && tx_ready;
    assign tick_s   = (baud_cnt_r == div_r);
    assign tx       = tx_r;
    assign busy     = busy_r;

    // Next-state and bit-index logic; every transition after IDLE waits for a bit tick.
    always_comb begin
        next_state_s = state_r;
        next_idx_s   = bit_idx_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_START;
                    next_idx_s   = {IDX_W{1'b0}};
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    next_state_s = ST_DATA;
                end else begin
                    next_state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    if (bit_idx_r != LAST_IDX) begin
                        next_idx_s = bit_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end else begin
`ifdef UART_TX_PARITY_EN
                        next_state_s = par_en_r ? ST_PARITY : ST_STOP1;
`else
                        next_state_s = ST_STOP1;
`endif
                    end
                end else begin
                    next_state_s = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick_s) begin
                    next_state_s = ST_STOP1;
                end else begin
                    next_state_s = ST_PARITY;
                end
            end
`endif
            ST_STOP1: begin
                if (tick_s) begin
                    next_state_s = stop2_r ? ST_STOP2 : ST_IDLE;
                end else begin
                    next_state_s = ST_STOP1;
                end
            end
            ST_STOP2: begin
                if (tick_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_STOP2;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                next_idx_s   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Baud counter and data word next values; the counter idles at zero and wraps on each tick.
    always_comb begin
        next_cnt_s  = baud_cnt_r;
        next_data_s = data_r;
        if ((state_r == ST_IDLE) || tick_s) begin
            next_cnt_s = {DIV_W{1'b0}};
        end else begin
            next_cnt_s = baud_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
        end
        if (accept_s) begin
            next_data_s = tx_data;
        end else begin
            next_data_s = data_r;
        end
    end

    // Line value for the state being entered, so tx is registered yet aligned with the state.
    always_comb begin
        next_tx_s = 1'b1;
        case (next_state_s)
            ST_IDLE:   next_tx_s = 1'b1;
            ST_START:  next_tx_s = 1'b0;
            ST_DATA:   next_tx_s = next_data_s[next_idx_s];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: next_tx_s = parity_bit(data_r, par_odd_r);
`endif
            ST_STOP1:  next_tx_s = 1'b1;
            ST_STOP2:  next_tx_s = 1'b1;
            default:   next_tx_s = 1'b1;
        endcase
    end

    // Frame state, counters, data word and registered line/busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            bit_idx_r  <= {IDX_W{1'b0}};
            baud_cnt_r <= {DIV_W{1'b0}};
            data_r     <= {DATA_W{1'b0}};
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            bit_idx_r  <= next_idx_s;
            baud_cnt_r <= next_cnt_s;
            data_r     <= next_data_s;
            tx_r       <= next_tx_s;
            busy_r     <= (next_state_s != ST_IDLE);
        end
    end

    // Per-frame snapshot of the CSR fields, taken on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r     <= {DIV_W{1'b0}};
            stop2_r   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_r  <= 1'b0;
            par_odd_r <= 1'b0;
`endif
        end else if (accept_s) begin
            div_r     <= baud_div;
            stop2_r   <= stop2;
`ifdef UART_TX_PARITY_EN
            par_en_r  <= parity_en;
            par_odd_r <= parity_odd;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed self-checking bench for uart_tx_engine (DATA_W=8, DIV_W=16).
// Expected frames are hand-written bit patterns, LSB = first bit on the line.
module tb_uart_tx_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] baud_div;
    logic        tx_en;
    logic        parity_en;
    logic        parity_odd;
    logic        stop2;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx;
    logic        busy;
    logic        free;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          div;
        logic [7:0]  data;
        logic        pe;
        logic        po;
        logic        s2;
        int          nbits;
        logic [15:0] pat;
    } vec_t;

    vec_t vecs[7];

    uart_tx_engine #(.DATA_W(8), .DIV_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_div   (baud_div),
        .tx_en      (tx_en),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .busy       (busy),
        .free       (free)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for tx_ready, applies a byte plus format, returns at the
    // falling edge of the first cycle after the accepting edge.
    task automatic send(input int d, input logic [7:0] data, input logic pe,
                        input logic po, input logic s2);
        int n;
        n = 0;
        while (tx_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'd0, tx_ready}, 32'd1);
        baud_div   = 16'(d);
        tx_data    = data;
        parity_en  = pe;
        parity_odd = po;
        stop2      = s2;
        tx_valid   = 1'b1;
        @(negedge clk);
    endtask

    // Checks a frame bit by bit (every cycle of each bit), then the idle state.
    // kind 1: at cycle evt_at set baud_div=7 and tx_en=0.
    // kind 2: pulse tx_valid with new data at cycle evt_at.
    task automatic run_frame(input string name, input int d, input logic [15:0] pat,
                             input int nbits, input int evt_at, input int kind,
                             input logic exp_ready);
        int cyc;
        int bad;
        tx_valid = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            bad = 0;
            for (int c = 0; c <= d; c++) begin
                cyc = b * (d + 1) + c;
                if (tx !== pat[b] || busy !== 1'b1) bad++;
                if (kind == 1 && cyc == evt_at) begin
                    baud_div = 16'd7;
                    tx_en    = 1'b0;
                end
                if (kind == 2 && cyc == evt_at) begin
                    tx_data  = 8'hC3;
                    tx_valid = 1'b1;
                end
                if (kind == 2 && cyc == evt_at + 1) tx_valid = 1'b0;
                @(negedge clk);
            end
            check($sformatf("%s_bit%0d_badcycles", name, b), 32'(bad), 32'd0);
        end
        check({name, "_end_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_end_tx"}, {31'd0, tx}, 32'd1);
        check({name, "_end_ready"}, {31'd0, tx_ready}, {31'd0, exp_ready});
    endtask

    logic [23:0] b2b_line;
    logic [23:0] b2b_busy;

    initial begin
        // div, data, pe, po, s2, nbits, pattern
        vecs[0] = '{3, 8'hA5, 1'b0, 1'b0, 1'b0, 10, 16'h034A};
`ifdef UART_TX_PARITY_EN
        vecs[1] = '{0, 8'hA5, 1'b1, 1'b0, 1'b0, 11, 16'h054A};
        vecs[2] = '{0, 8'hA5, 1'b1, 1'b1, 1'b0, 11, 16'h074A};
        vecs[5] = '{0, 8'h3C, 1'b1, 1'b0, 1'b1, 12, 16'h0C78};
        vecs[6] = '{0, 8'h01, 1'b1, 1'b1, 1'b0, 11, 16'h0402};
`else
        vecs[1] = '{0, 8'hA5, 1'b1, 1'b0, 1'b0, 10, 16'h034A};
        vecs[2] = '{0, 8'hA5, 1'b1, 1'b1, 1'b0, 10, 16'h034A};
        vecs[5] = '{0, 8'h3C, 1'b1, 1'b0, 1'b1, 11, 16'h0678};
        vecs[6] = '{0, 8'h01, 1'b1, 1'b1, 1'b0, 10, 16'h0202};
`endif
        vecs[3] = '{1, 8'h00, 1'b0, 1'b0, 1'b1, 11, 16'h0600};
        vecs[4] = '{2, 8'hFF, 1'b0, 1'b0, 1'b1, 11, 16'h07FE};

        rst_n      = 1'b0;
        baud_div   = 16'd0;
        tx_en      = 1'b0;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        stop2      = 1'b0;
        tx_data    = 8'h00;
        tx_valid   = 1'b0;

        // Reset state; ready/free follow tx_en during reset.
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready_dis", {31'd0, tx_ready}, 32'd0);
        tx_en = 1'b1;
        #1;
        check("rst_ready_en", {31'd0, tx_ready}, 32'd1);
        check("rst_free_en", {31'd0, free}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven frames.
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].div, vecs[i].data, vecs[i].pe, vecs[i].po, vecs[i].s2);
            run_frame($sformatf("vec%0d", i), vecs[i].div, vecs[i].pat,
                      vecs[i].nbits, -1, 0, 1'b1);
        end

        // Back-to-back with tx_valid held: 0x00 then 0xFF, two stop bits, div 0.
        b2b_line = 24'b11111111111_0_111_000000000;
        b2b_busy = 24'b0_11111111111_0_11111111111;
        send(0, 8'h00, 1'b0, 1'b0, 1'b1);
        tx_data = 8'hFF;
        for (int k = 0; k < 24; k++) begin
            check($sformatf("b2b_cyc%0d_tx_busy", k), {30'd0, tx, busy},
                  {30'd0, b2b_line[k], b2b_busy[k]});
            if (k == 11) check("b2b_idle_ready", {31'd0, tx_ready}, 32'd1);
            if (k == 12) tx_valid = 1'b0;
            @(negedge clk);
        end

        // Mid-frame CSR change: frame keeps 4 cycles/bit, no accept while disabled.
        send(3, 8'h5A, 1'b0, 1'b0, 1'b0);
        tx_data = 8'h0F;
        run_frame("midchg", 3, 16'h02B4, 10, 6, 1, 1'b0);
        tx_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("disabled_busy", {31'd0, busy}, 32'd0);
        check("disabled_ready", {31'd0, tx_ready}, 32'd0);
        check("disabled_tx", {31'd0, tx}, 32'd1);
        tx_en = 1'b1;
        @(negedge clk);
        run_frame("newdiv", 7, 16'h021E, 10, -1, 0, 1'b1);

        // Reset pulse during DATA: immediate idle, new byte on first edge after release.
        send(3, 8'hA5, 1'b0, 1'b0, 1'b0);
        tx_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_tx", {31'd0, tx}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        baud_div = 16'd0;
        tx_data  = 8'h81;
        tx_valid = 1'b1;
        rst_n    = 1'b1;
        @(negedge clk);
        run_frame("afterrst", 0, 16'h0302, 10, -1, 0, 1'b1);

        // tx_valid pulsed while busy is ignored.
        send(1, 8'h33, 1'b0, 1'b0, 1'b0);
        run_frame("notready", 1, 16'h0266, 10, 3, 2, 1'b1);
        repeat (8) begin
            check("notready_idle", {30'd0, tx, busy}, 32'd2);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
